// File: rtl/rv_ctrl_pkg.sv
// Shared opcodes, ALU codes and FSM state type
// for the multicycle control unit.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK
  } state_t;

  // funct3 to op for the base (funct7 = 0) form
  function automatic logic [3:0] base_alu(
    input logic [2:0] f3
  );
    logic [3:0] a;
    case (f3)
      3'd0:    a = ALU_ADD;
      3'd1:    a = ALU_SLL;
      3'd2:    a = ALU_SLT;
      3'd3:    a = ALU_SLTU;
      3'd4:    a = ALU_XOR;
      3'd5:    a = ALU_SRL;
      3'd6:    a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake, memory/MDU status and
// control strobes of the multicycle control unit.
interface multicycle_control_unit_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        mem_ack;
  logic        mdu_done;
  logic [3:0]  alu_control;
  logic        alu_src_imm;
  logic        regwrite;
  logic        mem_read;
  logic        mem_write;
  logic        pc_advance;
  logic        illegal_instr;
  logic        mem_err;

  modport master (
    output instr_valid,
    output instr,
    output mem_ack,
    output mdu_done,
    input  instr_ready,
    input  alu_control,
    input  alu_src_imm,
    input  regwrite,
    input  mem_read,
    input  mem_write,
    input  pc_advance,
    input  illegal_instr,
    input  mem_err
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  mem_ack,
    input  mdu_done,
    output instr_ready,
    output alu_control,
    output alu_src_imm,
    output regwrite,
    output mem_read,
    output mem_write,
    output pc_advance,
    output illegal_instr,
    output mem_err
  );

endinterface

// File: rtl/rv_alu_decoder.sv
// Combinational opcode/funct3/funct7 decoder.
// MUL decodes only with CU_MULDIV_EN defined.
module rv_alu_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int SRA_EN = 1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control,
  output logic       alu_src_imm,
  output logic       illegal
);

  logic is_r;
  logic is_imm;
  logic is_ld;
  logic is_st;
  logic f7_base;
  logic f7_alt;
  logic f7_mul;
  logic sra_ok;

  assign is_r    = (opcode == OP_R);
  assign is_imm  = (opcode == OP_IMM);
  assign is_ld   = (opcode == OP_LOAD);
  assign is_st   = (opcode == OP_STORE);
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);
  assign f7_mul  = (funct7 == F7_MULDIV);
  assign sra_ok  = (SRA_EN != 0);

  always_comb begin
    alu_control = ALU_ADD;
    alu_src_imm = 1'b0;
    illegal     = 1'b0;
    unique case (1'b1)
      is_r: begin
        unique case (1'b1)
          f7_base: alu_control = base_alu(funct3);
          f7_alt: begin
            if (funct3 == 3'd0)
              alu_control = ALU_SUB;
            else if (funct3 == 3'd5 && sra_ok)
              alu_control = ALU_SRA;
            else
              illegal = 1'b1;
          end
          f7_mul: begin
`ifdef CU_MULDIV_EN
            if (funct3 == 3'd0)
              alu_control = ALU_MUL;
            else
              illegal = 1'b1;
`else
            illegal = 1'b1;
`endif
          end
          default: illegal = 1'b1;
        endcase
      end
      is_imm: begin
        alu_src_imm = 1'b1;
        alu_control = base_alu(funct3);
        // imm[11:5] only qualifies the shift forms
        if (funct3 == 3'd1 && !f7_base)
          illegal = 1'b1;
        if (funct3 == 3'd5) begin
          if (f7_alt && sra_ok)
            alu_control = ALU_SRA;
          else if (!f7_base)
            illegal = 1'b1;
        end
      end
      is_ld: begin
        alu_src_imm = 1'b1;
        illegal = (funct3 == 3'd3)
               || (funct3 > 3'd5);
      end
      is_st: begin
        alu_src_imm = 1'b1;
        illegal = (funct3 > 3'd2);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM control unit with memory timeout.
// Optional MUL support: define CU_MULDIV_EN.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int SRA_EN      = 1
) (
  input logic clk,
  input logic rst,
  multicycle_control_unit_if.slave bus
);

  localparam logic [7:0] CNT_LAST =
    8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic [6:0] f7_q;
  logic [7:0] cnt;
  logic [3:0] alu_q;
  logic       imm_q;
  logic       ready_q;
  logic       rw_q;
  logic       rd_q;
  logic       wr_q;

  logic [3:0] dec_alu;
  logic       dec_imm;
  logic       dec_ill;
  logic       is_load;
  logic       is_store;
  logic       mdu_wait;
  logic       tmo;
  logic       unused_ok;

  rv_alu_decoder #(
    .SRA_EN (SRA_EN)
  ) u_dec (
    .opcode      (op_q),
    .funct3      (f3_q),
    .funct7      (f7_q),
    .alu_control (dec_alu),
    .alu_src_imm (dec_imm),
    .illegal     (dec_ill)
  );

  assign is_load  = (op_q == OP_LOAD);
  assign is_store = (op_q == OP_STORE);
  assign tmo      = (cnt == CNT_LAST);

`ifdef CU_MULDIV_EN
  assign mdu_wait = (alu_q == ALU_MUL)
                 && !bus.mdu_done;
  assign unused_ok = ^{bus.instr[24:15],
                       bus.instr[11:7]};
`else
  assign mdu_wait = 1'b0;
  assign unused_ok = ^{bus.instr[24:15],
                       bus.instr[11:7],
                       bus.mdu_done};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      cnt     <= '0;
      alu_q   <= ALU_ADD;
      imm_q   <= 1'b0;
      ready_q <= 1'b1;
      rw_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      rw_q <= 1'b0;
      unique case (state)
        FETCH: begin
          if (bus.instr_valid) begin
            op_q    <= bus.instr[6:0];
            f3_q    <= bus.instr[14:12];
            f7_q    <= bus.instr[31:25];
            ready_q <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (dec_ill) begin
            ready_q <= 1'b1;
            state   <= FETCH;
          end else begin
            alu_q <= dec_alu;
            imm_q <= dec_imm;
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (is_load || is_store) begin
            cnt   <= '0;
            rd_q  <= is_load;
            wr_q  <= is_store;
            state <= MEMORY;
          end else if (!mdu_wait) begin
            rw_q  <= 1'b1;
            state <= WRITEBACK;
          end
        end
        MEMORY: begin
          cnt <= cnt + 8'd1;
          // ack takes priority over a timeout
          if (bus.mem_ack || tmo) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (bus.mem_ack && is_load) begin
              rw_q  <= 1'b1;
              state <= WRITEBACK;
            end else begin
              ready_q <= 1'b1;
              state   <= FETCH;
            end
          end
        end
        WRITEBACK: begin
          ready_q <= 1'b1;
          state   <= FETCH;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= FETCH;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_control = alu_q;
  assign bus.alu_src_imm = imm_q;
  assign bus.regwrite    = rw_q;
  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;

  assign bus.illegal_instr =
    (state == DECODE) && dec_ill;

  assign bus.mem_err =
    (state == MEMORY) && !bus.mem_ack && tmo;

  assign bus.pc_advance =
    ((state == DECODE) && dec_ill)
    || (state == WRITEBACK)
    || ((state == MEMORY) && bus.mem_ack
        && is_store)
    || bus.mem_err;

endmodule
